uart_rx_ext: RTL and testbench

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_rx_ext.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with configurable frame format.
//   Samples each bit as a 2-of-3 majority near the end of the bit period.
//   Reports parity error, framing error and line break for every frame.
// Parameters:
//   CLKS_PER_BIT  i_Clock cycles per bit (8..65535)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 none, 1 odd, 2 even
//   STOP_BITS     stop bits checked per frame (1 or 2)
// Ports:
//   i_Clock       clock, all logic on the rising edge
//   i_Reset       synchronous active-high reset
//   i_Rx_Serial   asynchronous serial input, idle high
//   o_Rx_DV       one-cycle pulse, frame complete
//   o_Rx_Byte     received data, LSB first on the line
//   o_Parity_Err  parity mismatch in last frame
//   o_Frame_Err   a checked stop bit was 0 in last frame
//   o_Break       last frame was entirely zero
//   o_Busy        receiver is not idle
module uart_rx_ext #(
   parameter int unsigned CLKS_PER_BIT = 10416,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Break,
   output logic                 o_Busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] SAMP0_CNT = CNT_W'(CLKS_PER_BIT - 3);
   localparam logic [CNT_W-1:0] SAMP1_CNT = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PARITY    = 3'd3;
   localparam logic [2:0] S_STOP      = 3'd4;
   localparam logic [2:0] S_CLEANUP   = 3'd5;
   localparam logic [2:0] S_WAIT_IDLE = 3'd6;

   logic                 sync_meta, rx_s;
   logic [2:0]           state, state_next;
   logic [CNT_W-1:0]     clk_cnt, clk_cnt_next;
   logic [BIT_W-1:0]     bit_idx, bit_idx_next;
   logic [1:0]           samp, samp_next;
   logic [DATA_BITS-1:0] data_sr, data_next;
   logic                 par_acc, par_next;
   logic                 fe_acc, fe_next;
   logic                 zero_acc, zero_next;
   logic                 dv_next;
   logic [DATA_BITS-1:0] byte_next;
   logic                 pe_out_next, fe_out_next, brk_next, busy_next;
   logic                 maj, bit_end, par_err;

   // 2-of-3 vote over the two stored samples and the current synchronized line
   assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
   assign bit_end = (clk_cnt == LAST_CNT);

   // par_acc holds XOR of data and parity bits once the parity bit is taken
   always_comb begin
      par_err = 1'b0;
      if (PARITY == 1)      par_err = ~par_acc;
      else if (PARITY == 2) par_err = par_acc;
   end

   // State, counters and output registers
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync_meta    <= 1'b1;
         rx_s         <= 1'b1;
         state        <= S_IDLE;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         samp         <= '0;
         data_sr      <= '0;
         par_acc      <= 1'b0;
         fe_acc       <= 1'b0;
         zero_acc     <= 1'b0;
         o_Rx_DV      <= 1'b0;
         o_Rx_Byte    <= '0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Break      <= 1'b0;
         o_Busy       <= 1'b0;
      end else begin
         sync_meta    <= i_Rx_Serial;
         rx_s         <= sync_meta;
         state        <= state_next;
         clk_cnt      <= clk_cnt_next;
         bit_idx      <= bit_idx_next;
         samp         <= samp_next;
         data_sr      <= data_next;
         par_acc      <= par_next;
         fe_acc       <= fe_next;
         zero_acc     <= zero_next;
         o_Rx_DV      <= dv_next;
         o_Rx_Byte    <= byte_next;
         o_Parity_Err <= pe_out_next;
         o_Frame_Err  <= fe_out_next;
         o_Break      <= brk_next;
         o_Busy       <= busy_next;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_next   = state;
      clk_cnt_next = clk_cnt;
      bit_idx_next = bit_idx;
      samp_next    = samp;
      data_next    = data_sr;
      par_next     = par_acc;
      fe_next      = fe_acc;
      zero_next    = zero_acc;
      dv_next      = 1'b0;
      byte_next    = o_Rx_Byte;
      pe_out_next  = o_Parity_Err;
      fe_out_next  = o_Frame_Err;
      brk_next     = o_Break;

      if (clk_cnt == SAMP0_CNT) samp_next[0] = rx_s;
      if (clk_cnt == SAMP1_CNT) samp_next[1] = rx_s;

      case (state)
         S_IDLE: begin
            clk_cnt_next = '0;
            bit_idx_next = '0;
            if (!rx_s) state_next = S_START;
         end
         S_START: begin
            // re-check the line mid start bit to reject glitches
            if (clk_cnt == HALF_CNT) begin
               clk_cnt_next = '0;
               if (!rx_s) begin
                  state_next = S_DATA;
                  par_next   = 1'b0;
                  fe_next    = 1'b0;
                  zero_next  = 1'b1;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               clk_cnt_next = clk_cnt + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               clk_cnt_next       = '0;
               data_next[bit_idx] = maj;
               par_next           = par_acc ^ maj;
               zero_next          = zero_acc & ~maj;
               if (bit_idx == LAST_BIT) begin
                  bit_idx_next = '0;
                  state_next   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_next = bit_idx + BIT_W'(1);
               end
            end else begin
               clk_cnt_next = clk_cnt + CNT_W'(1);
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               clk_cnt_next = '0;
               par_next     = par_acc ^ maj;
               zero_next    = zero_acc & ~maj;
               state_next   = S_STOP;
            end else begin
               clk_cnt_next = clk_cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               clk_cnt_next = '0;
               fe_next      = fe_acc | ~maj;
               zero_next    = zero_acc & ~maj;
               if (bit_idx == LAST_STOP) begin
                  // publish the whole frame together with the DV pulse
                  bit_idx_next = '0;
                  state_next   = S_CLEANUP;
                  dv_next      = 1'b1;
                  byte_next    = data_sr;
                  pe_out_next  = par_err;
                  fe_out_next  = fe_acc | ~maj;
                  brk_next     = zero_acc & ~maj;
               end else begin
                  bit_idx_next = bit_idx + BIT_W'(1);
               end
            end else begin
               clk_cnt_next = clk_cnt + CNT_W'(1);
            end
         end
         S_CLEANUP: begin
            // after a framing error the line may still be in break; wait for idle
            state_next = o_Frame_Err ? S_WAIT_IDLE : S_IDLE;
         end
         S_WAIT_IDLE: begin
            if (rx_s) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase

      busy_next = (state_next != S_IDLE);
   end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: three instances (8N1, 8E1, 7N2) at 16 clocks per bit.
// A frame-level model queues the expected result of every frame sent and
// compares all instance outputs each cycle; directed literal checks pin it.
module tb_uart_rx_ext;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] line;
   wire  [2:0] dv, pe, fe, brk, busy;
   wire  [7:0] byte0, byte1;
   wire  [6:0] byte2;

   int          checks = 0;
   int          errors = 0;
   int          cycle  = 0;
   logic        rst_q  = 1'b1;
   logic [11:0] exp_mem [3][16];
   logic [11:0] held [3];
   int          wr_ptr [3];
   int          rd_ptr [3];
   int          dv_cnt [3];
   int          dv_cycle [3];
   logic        busy2 [3];

   always #5 clk = ~clk;

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[0]), .o_Rx_DV(dv[0]),
      .o_Rx_Byte(byte0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]),
      .o_Break(brk[0]), .o_Busy(busy[0]));

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[1]), .o_Rx_DV(dv[1]),
      .o_Rx_Byte(byte1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]),
      .o_Break(brk[1]), .o_Busy(busy[1]));

   uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(line[2]), .o_Rx_DV(dv[2]),
      .o_Rx_Byte(byte2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]),
      .o_Break(brk[2]), .o_Busy(busy[2]));

   // {byte(9), parity_err, frame_err, break}
   function automatic logic [11:0] actual(int i);
      case (i)
         0:       return {1'b0, byte0, pe[0], fe[0], brk[0]};
         1:       return {1'b0, byte1, pe[1], fe[1], brk[1]};
         default: return {2'b0, byte2, pe[2], fe[2], brk[2]};
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Held-output model: outputs change only on DV (to the next queued frame) or on reset
   task automatic monitor();
      logic [11:0] act;
      for (int i = 0; i < 3; i++) begin
         if (rst_q) begin
            held[i] = '0;
         end else if (dv[i]) begin
            dv_cnt[i]++;
            dv_cycle[i] = cycle;
            if (rd_ptr[i] == wr_ptr[i]) begin
               checks++;
               errors++;
               $display("FAIL unexpected_dv: dut%0d got DV expected none (cycle %0d)", i, cycle);
            end else begin
               held[i] = exp_mem[i][rd_ptr[i] % 16];
               rd_ptr[i]++;
            end
         end
         act = actual(i);
         checks++;
         if (act !== held[i]) begin
            errors++;
            $display("FAIL model_out dut%0d: got %h expected %h (cycle %0d)", i, act, held[i], cycle);
         end
         if (cycle == dv_cycle[i] + 2) busy2[i] = busy[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      rst_q = rst;
      @(negedge clk);
      cycle++;
      monitor();
   endtask

   task automatic push_exp(input int i, input logic [11:0] v);
      exp_mem[i][wr_ptr[i] % 16] = v;
      wr_ptr[i]++;
   endtask

   // Send one frame on line i; gb/go invert a single cycle (frame bit gb, offset go)
   task automatic frame(input int i, input logic [8:0] d, input int nd, input int pmode,
                        input logic pbit, input logic [1:0] stops, input int ns,
                        input int gb, input int go);
      logic [15:0] bits;
      logic [8:0]  dm;
      int          n;
      logic        x, pe_e, fe_e, brk_e, stops_zero;
      dm   = d & 9'((1 << nd) - 1);
      bits = '0;
      n    = 1;
      for (int k = 0; k < nd; k++) begin bits[n] = d[k]; n++; end
      if (pmode != 0) begin bits[n] = pbit; n++; end
      for (int k = 0; k < ns; k++) begin bits[n] = stops[k]; n++; end
      x          = (^dm) ^ pbit;
      pe_e       = (pmode == 1) ? ~x : (pmode == 2) ? x : 1'b0;
      fe_e       = (ns == 2) ? ~(stops[0] & stops[1]) : ~stops[0];
      stops_zero = (ns == 2) ? (stops == 2'b00) : ~stops[0];
      brk_e      = (dm == 9'd0) && (pmode == 0 || !pbit) && stops_zero;
      push_exp(i, {dm, pe_e, fe_e, brk_e});
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < CPB; c++) begin
            line[i] = (b == gb && c == go) ? ~bits[b] : bits[b];
            tick();
         end
      end
      line[i] = 1'b1;
      repeat (2 * CPB) tick();
   endtask

   task automatic wait_dv(input int i, input int target);
      for (int n = 0; n < 400 && dv_cnt[i] < target; n++) tick();
      chk($sformatf("dv_count_dut%0d", i), dv_cnt[i], target);
   endtask

   initial begin
      rst  = 1'b1;
      line = 3'b111;
      for (int i = 0; i < 3; i++) begin
         wr_ptr[i] = 0; rd_ptr[i] = 0; dv_cnt[i] = 0;
         dv_cycle[i] = -100; held[i] = '0; busy2[i] = 1'b1;
      end
      repeat (3) tick();
      chk("rst_dv", dv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bytes", {byte0, byte1, byte2}, 0);
      chk("rst_flags", {pe, fe, brk}, 0);
      rst = 1'b0;
      repeat (4) tick();

      // 8N1 0xA5
      frame(0, 9'h0A5, 8, 0, 1'b0, 2'b01, 1, -1, 0);
      wait_dv(0, 1);
      chk("a5_byte", byte0, 'hA5);
      chk("a5_flags", {pe[0], fe[0], brk[0]}, 0);
      chk("a5_busy_after_dv", busy2[0], 0);

      // 8E1 0x37, wrong then right parity bit
      frame(1, 9'h037, 8, 2, 1'b0, 2'b01, 1, -1, 0);
      wait_dv(1, 1);
      chk("p37_byte_bad", byte1, 'h37);
      chk("p37_perr_bad", pe[1], 1);
      chk("p37_ferr_bad", fe[1], 0);
      frame(1, 9'h037, 8, 2, 1'b1, 2'b01, 1, -1, 0);
      wait_dv(1, 2);
      chk("p37_byte_good", byte1, 'h37);
      chk("p37_perr_good", pe[1], 0);

      // false start
      line[0] = 1'b0;
      repeat (4) tick();
      line[0] = 1'b1;
      repeat (3 * CPB) tick();
      chk("false_start_dv", dv_cnt[0], 1);
      chk("false_start_busy", busy[0], 0);
      chk("false_start_byte", byte0, 'hA5);

      // break: 12 bit times low
      push_exp(0, {9'h000, 1'b0, 1'b1, 1'b1});
      line[0] = 1'b0;
      repeat (12 * CPB) tick();
      chk("brk_dv", dv_cnt[0], 2);
      chk("brk_busy_line_low", busy[0], 1);
      chk("brk_byte", byte0, 0);
      chk("brk_flags", {pe[0], fe[0], brk[0]}, 3'b011);
      line[0] = 1'b1;
      repeat (3 * CPB) tick();
      chk("brk_no_second_dv", dv_cnt[0], 2);
      chk("brk_idle_busy", busy[0], 0);
      frame(0, 9'h03C, 8, 0, 1'b0, 2'b01, 1, -1, 0);
      wait_dv(0, 3);
      chk("post_brk_byte", byte0, 'h3C);
      chk("post_brk_flags", {pe[0], fe[0], brk[0]}, 0);

      // single-cycle glitch in data bit 3 (frame bit 4) at DUT count 14
      frame(0, 9'h00F, 8, 0, 1'b0, 2'b01, 1, 4, 7);
      wait_dv(0, 4);
      chk("glitch_byte", byte0, 'h0F);
      chk("glitch_flags", {pe[0], fe[0], brk[0]}, 0);

      // 7N2, second stop bit 0
      frame(2, 9'h055, 7, 0, 1'b0, 2'b01, 2, -1, 0);
      wait_dv(2, 1);
      chk("s2_byte", byte2, 'h55);
      chk("s2_flags", {pe[2], fe[2], brk[2]}, 3'b010);

      // reset during data bit 4 of the next frame
      line[2] = 1'b0;
      repeat (CPB) tick();
      for (int k = 0; k < 4; k++) begin
         line[2] = k[0];
         repeat (CPB) tick();
      end
      line[2] = 1'b0;
      repeat (CPB / 2) tick();
      rst     = 1'b1;
      line[2] = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (3 * CPB) tick();
      chk("abort_dv", dv_cnt[2], 1);
      chk("abort_byte", byte2, 0);
      chk("abort_flags", {pe[2], fe[2], brk[2]}, 0);
      chk("abort_busy", busy, 0);
      frame(2, 9'h02A, 7, 0, 1'b0, 2'b11, 2, -1, 0);
      wait_dv(2, 2);
      chk("post_rst_byte", byte2, 'h2A);
      chk("post_rst_flags", {pe[2], fe[2], brk[2]}, 0);

      for (int i = 0; i < 3; i++) chk($sformatf("exp_drained_dut%0d", i), rd_ptr[i], wr_ptr[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
